// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// Contents: immediate format enum, in_sel override codes, RV opcode values.
package imm_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned OPC_W   = 7;

  // Immediate format; the numeric codes of I..SHAMT match the in_sel override codes.
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

  localparam logic [SEL_W-1:0] SEL_AUTO  = 3'd0;
  localparam logic [SEL_W-1:0] SEL_I     = 3'd1;
  localparam logic [SEL_W-1:0] SEL_S     = 3'd2;
  localparam logic [SEL_W-1:0] SEL_B     = 3'd3;
  localparam logic [SEL_W-1:0] SEL_U     = 3'd4;
  localparam logic [SEL_W-1:0] SEL_J     = 3'd5;
  localparam logic [SEL_W-1:0] SEL_SHAMT = 3'd6;
  localparam logic [SEL_W-1:0] SEL_RSVD  = 3'd7;

  localparam logic [OPC_W-1:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;

  // funct3 values of the OP-IMM shift-immediate instructions
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate-format resolver.
// Ports: opcode/funct3 of the instruction, sel override code in; fmt_c resolved format out.
module imm_decode
  import imm_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic [2:0]       funct3,
  input  logic [SEL_W-1:0] sel,
  output imm_fmt_e         fmt_c
);

  imm_fmt_e auto_fmt;

  // Opcode-driven format for AUTO selection
  always_comb begin
    auto_fmt = FMT_NONE;
    case (opcode)
      OPC_OP_IMM:    auto_fmt = (funct3 == F3_SLLI || funct3 == F3_SRXI) ? FMT_SHAMT : FMT_I;
      OPC_LOAD,
      OPC_JALR,
      OPC_OP_IMM_32: auto_fmt = FMT_I;
      OPC_STORE:     auto_fmt = FMT_S;
      OPC_BRANCH:    auto_fmt = FMT_B;
      OPC_LUI,
      OPC_AUIPC:     auto_fmt = FMT_U;
      OPC_JAL:       auto_fmt = FMT_J;
      default:       auto_fmt = FMT_NONE;
    endcase
  end

  // Forced formats override the opcode; the reserved code yields no format
  always_comb begin
    fmt_c = FMT_NONE;
    case (sel)
      SEL_AUTO:  fmt_c = auto_fmt;
      SEL_I:     fmt_c = FMT_I;
      SEL_S:     fmt_c = FMT_S;
      SEL_B:     fmt_c = FMT_B;
      SEL_U:     fmt_c = FMT_U;
      SEL_J:     fmt_c = FMT_J;
      SEL_SHAMT: fmt_c = FMT_SHAMT;
      default:   fmt_c = FMT_NONE;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage pipelined immediate generator with valid/ready handshake and flush.
// Ports: clk, reset_n (async active-low), flush;
//        in_valid/in_ready/in_instr/in_sel  - instruction beat in;
//        out_valid/out_ready/out_imm/out_fmt/out_illegal - extended immediate out.
// in_ready is combinational from out_ready and flush.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [SEL_W-1:0]   in_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic [2:0]         out_fmt,
  output logic               out_illegal
);

  // Stage 1 keeps only bits 31:7; the opcode is consumed by the decoder at accept time.
  logic        s1_valid;
  logic [31:7] s1_instr;
  imm_fmt_e    s1_fmt;

  imm_fmt_e    dec_fmt_c;
  logic        s2_take;
  logic        s1_advance;
  logic        accept;
  logic [63:0] imm64;
  logic [XLEN-1:0] ext_imm;

  imm_decode u_decode (
    .opcode (in_instr[6:0]),
    .funct3 (in_instr[14:12]),
    .sel    (in_sel),
    .fmt_c  (dec_fmt_c)
  );

  // Handshake: a stage moves when the one downstream is empty or draining
  assign s2_take    = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_take;
  assign in_ready   = !flush && (!s1_valid || s1_advance);
  assign accept     = in_valid && in_ready;

  // Extension computed at 64 bits, then narrowed to XLEN (sign already replicated)
  always_comb begin
    imm64 = '0;
    case (s1_fmt)
      FMT_I:     imm64 = {{52{s1_instr[31]}}, s1_instr[31:20]};
      FMT_S:     imm64 = {{52{s1_instr[31]}}, s1_instr[31:25], s1_instr[11:7]};
      FMT_B:     imm64 = {{51{s1_instr[31]}}, s1_instr[31], s1_instr[7],
                          s1_instr[30:25], s1_instr[11:8], 1'b0};
      FMT_U:     imm64 = {{32{s1_instr[31]}}, s1_instr[31:12], 12'b0};
      FMT_J:     imm64 = {{43{s1_instr[31]}}, s1_instr[31], s1_instr[19:12],
                          s1_instr[20], s1_instr[30:21], 1'b0};
      FMT_SHAMT: imm64 = (XLEN == 64) ? {58'b0, s1_instr[25:20]} : {59'b0, s1_instr[24:20]};
      default:   imm64 = '0;
    endcase
  end

  assign ext_imm = XLEN'(imm64);

  // Stage 1: instruction bits and resolved format
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_fmt   <= FMT_NONE;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept || (s1_valid && !s1_advance);
      if (accept) begin
        s1_instr <= in_instr[31:7];
        s1_fmt   <= dec_fmt_c;
      end
    end
  end

  // Stage 2: output register, held while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_fmt     <= FMT_NONE;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_take) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_imm     <= ext_imm;
        out_fmt     <= s1_fmt;
        out_illegal <= (s1_fmt == FMT_NONE);
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=64 and XLEN=32 instances share stimulus.
module tb_imm_gen_pipe;

  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_SHAMT = 3'd6;

  typedef struct {
    logic [2:0]  fmt;
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_sel;
  logic        out_ready;

  logic        rdy64, ov64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic        rdy32, ov32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;

  int checks = 0;
  int passes = 0;
  int delivered = 0;
  exp_t q[$];

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_sel(in_sel),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(ill64)
  );

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_sel(in_sel),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
    .out_illegal(ill32)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: immediate value built arithmetically from field weights
  function automatic exp_t model(input logic [31:0] ins, input logic [2:0] sel);
    exp_t e;
    logic [2:0]  f;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [63:0] v;
    logic        sgn;
    opc = ins[6:0];
    f3  = ins[14:12];
    sgn = ins[31];
    f   = F_NONE;
    v   = 64'd0;
    if (sel == 3'd0) begin
      if (opc == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) f = F_SHAMT;
      else if (opc == 7'h13 || opc == 7'h03 || opc == 7'h67 || opc == 7'h1B) f = F_I;
      else if (opc == 7'h23) f = F_S;
      else if (opc == 7'h63) f = F_B;
      else if (opc == 7'h37 || opc == 7'h17) f = F_U;
      else if (opc == 7'h6F) f = F_J;
    end else if (sel != 3'd7) begin
      f = sel;
    end
    case (f)
      F_I:     v = 64'(ins[31:20]) - (sgn ? 64'd4096 : 64'd0);
      F_S:     v = 64'(ins[11:7]) + 64'(ins[31:25]) * 64'd32 - (sgn ? 64'd4096 : 64'd0);
      F_B:     v = 64'(ins[11:8]) * 64'd2 + 64'(ins[30:25]) * 64'd32
                   + 64'(ins[7]) * 64'd2048 - (sgn ? 64'd4096 : 64'd0);
      F_U:     v = 64'(ins[31:12]) * 64'd4096 - (sgn ? 64'h1_0000_0000 : 64'd0);
      F_J:     v = 64'(ins[30:21]) * 64'd2 + 64'(ins[20]) * 64'd2048
                   + 64'(ins[19:12]) * 64'd4096 - (sgn ? 64'h10_0000 : 64'd0);
      F_SHAMT: v = 64'(ins[25:20]);
      default: v = 64'd0;
    endcase
    e.fmt   = f;
    e.imm64 = v;
    e.imm32 = (f == F_SHAMT) ? 32'(ins[24:20]) : v[31:0];
    e.ill   = (f == F_NONE);
    return e;
  endfunction

  // One clock of stimulus; checks handshake and scoreboard before the next rising edge
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [2:0] sel,
                       input logic ordy, input logic fl);
    exp_t e;
    logic exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_instr  = ins;
    in_sel    = sel;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = !fl && !(q.size() >= 2 && !ordy);
    chk("in_ready64", 64'(rdy64), 64'(exp_rdy));
    chk("in_ready32", 64'(rdy32), 64'(exp_rdy));
    if (q.size() == 0) begin
      chk("idle_out_valid64", 64'(ov64), 64'd0);
      chk("idle_out_valid32", 64'(ov32), 64'd0);
    end else if (ov64 && ordy) begin
      e = q.pop_front();
      delivered++;
      chk("sb_imm64", imm64, e.imm64);
      chk("sb_fmt64", 64'(fmt64), 64'(e.fmt));
      chk("sb_ill64", 64'(ill64), 64'(e.ill));
      chk("sb_valid32", 64'(ov32), 64'd1);
      chk("sb_imm32", 64'(imm32), 64'(e.imm32));
      chk("sb_fmt32", 64'(fmt32), 64'(e.fmt));
      chk("sb_ill32", 64'(ill32), 64'(e.ill));
    end
    if (fl) q.delete();
    else if (v && rdy64) q.push_back(model(ins, sel));
  endtask

  // Single beat into an empty pipe: absent at N+1, present with fixed values at N+2
  task automatic directed(input string tag, input logic [31:0] ins, input logic [2:0] sel,
                          input logic [63:0] x64, input logic [31:0] x32,
                          input logic [2:0] xf, input logic xi);
    cycle(1'b1, ins, sel, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
    chk({tag, "_early"}, 64'(ov64), 64'd0);
    cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
    chk({tag, "_valid"}, 64'(ov64), 64'd1);
    chk({tag, "_imm64"}, imm64, x64);
    chk({tag, "_imm32"}, 64'(imm32), 64'(x32));
    chk({tag, "_fmt"}, 64'(fmt64), 64'(xf));
    chk({tag, "_ill"}, 64'(ill64), 64'(xi));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  pool [10];
    logic [31:0] r;
    pool = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    r = $urandom();
    return {r[31:7], pool[$urandom_range(0, 9)]};
  endfunction

  initial begin
    int d0;
    logic [2:0] rs;
    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0;
    in_sel = 3'd0; out_ready = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_out_valid", 64'(ov64), 64'd0);
    chk("rst_out_imm", imm64, 64'd0);
    chk("rst_out_fmt", 64'(fmt64), 64'(F_NONE));
    chk("rst_out_illegal", 64'(ill64), 64'd0);
    chk("rst_in_ready", 64'(rdy64), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed format vectors
    directed("auto_i",   32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, F_I, 1'b0);
    directed("auto_s",   32'hFE112E23, 3'd0, 64'hFFFFFFFFFFFFFFFC, 32'hFFFFFFFC, F_S, 1'b0);
    directed("auto_b",   32'hFE000CE3, 3'd0, 64'hFFFFFFFFFFFFFFF8, 32'hFFFFFFF8, F_B, 1'b0);
    directed("auto_u",   32'h80000537, 3'd0, 64'hFFFFFFFF80000000, 32'h80000000, F_U, 1'b0);
    directed("auto_j",   32'h8000006F, 3'd0, 64'hFFFFFFFFFFF00000, 32'hFFF00000, F_J, 1'b0);
    directed("shamt",    32'h03F09093, 3'd0, 64'd63, 32'd31, F_SHAMT, 1'b0);
    directed("rtype",    32'h002081B3, 3'd0, 64'd0, 32'd0, F_NONE, 1'b1);
    directed("forced_i", 32'h002081B3, 3'd1, 64'd2, 32'd2, F_I, 1'b0);

    // Back-to-back stream with out_ready high
    d0 = delivered;
    for (int i = 0; i < 8; i++) cycle(1'b1, rand_instr(), 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
    chk("stream_count", 64'(delivered - d0), 64'd8);

    // Backpressure: out_ready toggles every other cycle
    d0 = delivered;
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 40 && (delivered - d0) < 8; c++) begin
        cycle(sent < 8, rand_instr(), 3'd0, c[0], 1'b0);
        if (sent < 8 && in_ready_seen()) sent++;
      end
    end
    chk("bp_count", 64'(delivered - d0), 64'd8);
    chk("bp_empty", 64'(q.size()), 64'd0);

    // Flush with two beats in flight plus a concurrent beat
    cycle(1'b1, 32'hFFF00093, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE112E23, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'h80000537, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
      chk("flush_no_out", 64'(ov64), 64'd0);
    end
    directed("post_flush", 32'hFE000CE3, 3'd0, 64'hFFFFFFFFFFFFFFF8, 32'hFFFFFFF8, F_B, 1'b0);

    // Reset mid-stream with both stages full
    cycle(1'b1, 32'hFFF00093, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 32'hFE112E23, 3'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid64", 64'(ov64), 64'd0);
    chk("midrst_out_valid32", 64'(ov32), 64'd0);
    chk("midrst_in_ready", 64'(rdy64), 64'd1);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
    directed("rsvd_sel", 32'hFFF00093, 3'd7, 64'd0, 32'd0, F_NONE, 1'b1);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 1)), rand_instr(), rs,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Whether the beat presented in the cycle just driven was taken
  function automatic logic in_ready_seen();
    return in_valid && rdy64 && !flush;
  endfunction

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RISC-V datapath; successor to the single-cycle combinational sign-extend unit. Accepts one instruction word per cycle over a valid/ready handshake, decodes the immediate format from the opcode (or takes a forced format), and returns the XLEN-bit extended immediate after a fixed two-stage pipeline with full backpressure and flush. Sits between instruction fetch/decode and the ALU/branch-target operand muxes.

## Interface
- XLEN, 64: output immediate width; legal values 32 or 64.
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops all in-flight entries.
- in_valid  in  1  instruction beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_instr  in  32  instruction word.
- in_sel  in  3  0 AUTO, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 reserved.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format used (imm_fmt_e).
- out_illegal  out  1  no immediate format applies.

## Operation
- AUTO decode: opcode 0010011/0000011/1100111/0011011 -> I; 0010011 with funct3 001 or 101 -> SHAMT; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; anything else -> NONE.
- Extraction, sign bit always instr[31] except SHAMT:
- I: sext(instr[31:20]). S: sext({instr[31:25],instr[11:7]}).
- B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
- U: sext({instr[31:12],12'b0}) from bit 31 to XLEN.
- J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
- SHAMT: zero-extended instr[25:20] when XLEN=64, instr[24:20] when XLEN=32.
- NONE or in_sel=7: out_imm=0, out_fmt=FMT_NONE, out_illegal=1.
- Stage 1 registers instr and resolved format; stage 2 registers extended immediate, format, illegal.
- Each stage holds a valid bit; stage advances when the next stage is empty or advancing. in_ready = !s1_valid || s1_advance (combinational from out_ready).
- Output held stable while out_valid && !out_ready.

## Timing
- Reset: s1/s2 valid=0, out_valid=0, out_imm=0, out_fmt=FMT_NONE, out_illegal=0; in_ready=1 during and after reset.
- Latency: beat accepted in cycle N appears with out_valid in N+2 when unstalled.
- Throughput: one beat per cycle with out_ready held high.
- Backpressure: out_ready low with both stages full -> in_ready low same cycle; no beat lost or duplicated.
- flush: clears both valid bits next edge; in_ready forced 0 in the flush cycle, so a concurrent in_valid beat is not accepted. flush wins over every other event.
- Reset asserted mid-operation: all entries discarded immediately; no output beat after release until a new beat is accepted.

## Structure
- imm_pkg: imm_fmt_e (NONE, I, S, B, U, J, SHAMT), in_sel codes, opcode localparams.
- Sub-module imm_decode: combinational opcode/in_sel -> imm_fmt_e; instantiated in stage 1.
- Extension logic inline in imm_gen_pipe, stage 2.

## Test plan
- AUTO, XLEN=64: 0xFFF00093 -> out_imm 0xFFFFFFFFFFFFFFFF, fmt I, two cycles after acceptance; 0xFE112E23 -> 0xFFFFFFFFFFFFFFFC, fmt S.
- Branch/upper: 0xFE000CE3 -> 0xFFFFFFFFFFFFFFF8, fmt B; 0x80000537 -> 0xFFFFFFFF80000000, fmt U; XLEN=32 same -> 0x80000000.
- Shift: 0x03F09093 AUTO -> out_imm 63, fmt SHAMT, illegal 0; R-type 0x002081B3 -> imm 0, illegal 1.
- Backpressure: stream 8 back-to-back beats, out_ready toggled every other cycle -> all 8 results in order, no drop/duplicate, in_ready low only while both stages full and stalled.
- Flush: 2 beats in flight plus in_valid during flush -> no out_valid for any of the 3; next beat after flush returns with 2-cycle latency.
- Reset mid-stream: reset_n low with both stages full -> out_valid 0 asynchronously, in_ready 1; in_sel=7 beat afterwards -> illegal 1, imm 0.
